// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: four 8-bit registers shared by two requesters through a
// three-state access FSM (StIdle -> StAccess -> StResp -> StIdle).
//
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   reqN_valid/we/addr/wdata   requester N transaction (N = 0, 1)
//   reqN_ready                 accept handshake, only in StIdle, only for the grantee
//   rspN_valid/rdata           one-cycle response strobe; rdata is zero when not valid
//   bank_q                     register contents, reg3 in [31:24] .. reg0 in [7:0]
//   busy                       high whenever the FSM is not in StIdle
//
// Build option: define REG_BANK_ARB_FIXED_PRIO_EN to make requester 0 win
// every tie; otherwise ties are resolved round-robin.
module reg_bank_arbiter #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [1:0]  req0_addr,
  input  logic [7:0]  req0_wdata,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [1:0]  req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [7:0]  rsp0_rdata,
  output logic        rsp1_valid,
  output logic [7:0]  rsp1_rdata,
  output logic [31:0] bank_q,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0][7:0] regs_q, regs_d;
  logic            gnt_q, gnt_d;
  logic            we_q, we_d;
  logic [1:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            gnt_sel;
  logic            accept;

`ifdef REG_BANK_ARB_FIXED_PRIO_EN
  assign gnt_sel = req0_valid ? 1'b0 : req1_valid;
`else
  // prio_q names the requester that wins the next tie.
  logic prio_q, prio_d;
  assign gnt_sel = (req0_valid && req1_valid) ? prio_q : req1_valid;
`endif

  // Gating with rst_n keeps every handshake quiet while reset is asserted.
  assign accept     = rst_n && (state_q == StIdle) && (req0_valid || req1_valid);
  assign req0_ready = accept && !gnt_sel;
  assign req1_ready = accept && gnt_sel;

  assign rsp0_valid = rst_n && (state_q == StResp) && !gnt_q;
  assign rsp1_valid = rst_n && (state_q == StResp) && gnt_q;
  assign rsp0_rdata = rsp0_valid ? rdata_q : 8'h00;
  assign rsp1_rdata = rsp1_valid ? rdata_q : 8'h00;
  assign busy       = rst_n && (state_q != StIdle);
  assign bank_q     = regs_q;

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifndef REG_BANK_ARB_FIXED_PRIO_EN
    prio_d  = prio_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StAccess;
          gnt_d   = gnt_sel;
          we_d    = gnt_sel ? req1_we    : req0_we;
          addr_d  = gnt_sel ? req1_addr  : req0_addr;
          wdata_d = gnt_sel ? req1_wdata : req0_wdata;
`ifndef REG_BANK_ARB_FIXED_PRIO_EN
          prio_d  = !gnt_sel;
`endif
        end
      end
      StAccess: begin
        state_d = StResp;
        // Response carries the post-write value of the addressed register.
        if (we_q) begin
          regs_d[addr_q] = wdata_q;
          rdata_d        = wdata_q;
        end else begin
          rdata_d        = regs_q[addr_q];
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      regs_q  <= {4{RESET_VAL}};
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 2'd0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifndef REG_BANK_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end
`endif

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter. Inputs change on the
// falling edge; outputs are sampled on the falling edge (or #1 after it).
module tb_reg_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [1:0]  req0_addr, req1_addr;
  logic [7:0]  req0_wdata, req1_wdata;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [7:0]  rsp0_rdata, rsp1_rdata;
  logic [31:0] bank_q;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_bank_arbiter #(.RESET_VAL(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .bank_q     (bank_q),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // At most one ready may ever be high.
  always @(negedge clk) check_eq("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);

  // Full transaction for one requester; starts and ends on a falling edge.
  task automatic issue(input bit n, input bit we, input logic [1:0] addr,
                       input logic [7:0] wdata, input logic [7:0] exp_rd,
                       input logic [31:0] exp_bank, output int waited);
    if (n) begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end else begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end
    waited = 0;
    #1;
    while (!(n ? req1_ready : req0_ready) && waited < 10) begin
      @(negedge clk); #1;
      waited++;
    end
    check_eq("accept_ready", {31'd0, n ? req1_ready : req0_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (n) req1_valid = 1'b0; else req0_valid = 1'b0;
    check_eq("access_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("rsp_valid", {31'd0, n ? rsp1_valid : rsp0_valid}, 32'd1);
    check_eq("rsp_rdata", {24'd0, n ? rsp1_rdata : rsp0_rdata}, {24'd0, exp_rd});
    check_eq("rsp_other", {31'd0, n ? rsp0_valid : rsp1_valid}, 32'd0);
    check_eq("bank", bank_q, exp_bank);
    @(negedge clk);
    check_eq("rsp_one_cycle", {31'd0, n ? rsp1_valid : rsp0_valid}, 32'd0);
    check_eq("rdata_idle_zero", {24'd0, n ? rsp1_rdata : rsp0_rdata}, 32'd0);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [31:0] exp_b;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 2'd0; req0_wdata = 8'h00;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 2'd0; req1_wdata = 8'h00;

    // Reset state, with req0 valid to show ready stays low in reset.
    repeat (2) @(negedge clk);
    check_eq("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_rsp0", {31'd0, rsp0_valid}, 32'd0);
    check_eq("rst_rsp1", {31'd0, rsp1_valid}, 32'd0);
    check_eq("rst_bank", bank_q, 32'h0000_0000);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read from the other requester.
    issue(1'b0, 1'b1, 2'd2, 8'hA5, 8'hA5, 32'h00A5_0000, w);
    issue(1'b1, 1'b0, 2'd2, 8'h00, 8'hA5, 32'h00A5_0000, w);

    // Tie: last accept was req1, so req0 goes first; req1 waits through busy.
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 2'd0; req0_wdata = 8'h11;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 2'd0; req1_wdata = 8'h22;
    #1;
    check_eq("tie1_ready0", {31'd0, req0_ready}, 32'd1);
    check_eq("tie1_ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check_eq("wait_access_ready1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    check_eq("tie1_rsp0", {31'd0, rsp0_valid}, 32'd1);
    check_eq("tie1_rdata0", {24'd0, rsp0_rdata}, 32'h11);
    check_eq("wait_resp_ready1", {31'd0, req1_ready}, 32'd0);
    check_eq("tie1_bank", bank_q, 32'h00A5_0011);
    @(negedge clk); #1;
    check_eq("idle_ready1", {31'd0, req1_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    check_eq("tie1_rsp1", {31'd0, rsp1_valid}, 32'd1);
    check_eq("tie1_rdata1", {24'd0, rsp1_rdata}, 32'h22);
    check_eq("tie1_rsp0_low", {31'd0, rsp0_valid}, 32'd0);
    check_eq("tie1_bank_final", bank_q, 32'h00A5_0022);
    @(negedge clk);

    // Next tie goes to req0 again; the one after that depends on the build.
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 2'd2;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 2'd2;
    #1;
    check_eq("tie2_ready0", {31'd0, req0_ready}, 32'd1);
    check_eq("tie2_ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    check_eq("tie2_rdata0", {24'd0, rsp0_rdata}, 32'hA5);
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
`ifdef REG_BANK_ARB_FIXED_PRIO_EN
    check_eq("tie3_ready0", {31'd0, req0_ready}, 32'd1);
`else
    check_eq("tie3_ready1", {31'd0, req1_ready}, 32'd1);
`endif
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("tie3_done_busy", {31'd0, busy}, 32'd0);

    // Reset during ACCESS abandons the write.
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 2'd1; req0_wdata = 8'h3C;
    #1;
    check_eq("abort_ready0", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_rsp0", {31'd0, rsp0_valid}, 32'd0);
    check_eq("abort_bank", bank_q, 32'h0000_0000);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_rsp0_after", {31'd0, rsp0_valid}, 32'd0);
    check_eq("abort_busy_after", {31'd0, busy}, 32'd0);
    check_eq("abort_bank_after", bank_q, 32'h0000_0000);

    // Back-to-back writes: each accept follows the previous by 3 cycles.
    exp_b = 32'h0;
    for (int i = 0; i < 4; i++) begin
      exp_b[8*i +: 8] = 8'(i + 1);
      issue(1'b0, 1'b1, 2'(i), 8'(i + 1), 8'(i + 1), exp_b, w);
      check_eq("b2b_wait", 32'(w), 32'd0);
    end
    check_eq("b2b_bank", bank_q, 32'h0403_0201);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
